// File: rtl/ce_gen_pkg.sv
// rtl/ce_gen_pkg.sv - shared constants, divisor type and bus-extraction helper for ce_gen
package ce_gen_pkg;

    localparam int CNT_W_DEF    = 4;
    localparam int MAX_CHANNELS = 8;
    localparam int MAX_CNT_W    = 8;
    localparam int BUS_W        = MAX_CHANNELS * MAX_CNT_W;

    typedef logic [CNT_W_DEF-1:0] divisor_t;

    // Pull channel idx's w-bit divisor out of a packed bus (zero-extended to
    // the widest legal layout), returned right-aligned and zero-padded.
    function automatic logic [MAX_CNT_W-1:0] get_div(
        input logic [BUS_W-1:0] bus,
        input int               idx,
        input int               w
    );
        logic [BUS_W-1:0]     shifted;
        logic [MAX_CNT_W-1:0] mask;
        shifted = bus >> (idx * w);
        mask    = '1;
        mask    = mask >> (MAX_CNT_W - w);
        return shifted[MAX_CNT_W-1:0] & mask;
    endfunction

endpackage

// File: rtl/ce_chan.sv
// rtl/ce_chan.sv - one clock-enable channel: reloadable down-counter with pause and align
//
// Ports:
//   clk_sys, reset_n   clock, asynchronous active-low reset
//   div_normal         divisor used at wrap when turbo = 0
//   div_turbo          divisor used at wrap when turbo = 1
//   turbo, pause, align shared controls (align beats pause)
//   ce                 registered enable pulse, high 1 cycle in every D
//   mode               turbo value captured at the last reload
module ce_chan #(
    parameter int CNT_W = 4
) (
    input  logic             clk_sys,
    input  logic             reset_n,
    input  logic [CNT_W-1:0] div_normal,
    input  logic [CNT_W-1:0] div_turbo,
    input  logic             turbo,
    input  logic             pause,
    input  logic             align,
    output logic             ce,
    output logic             mode
);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] sel;

    // Divisor selection only matters at wrap, so switches never disturb a
    // period already in progress.
    assign sel = turbo ? div_turbo : div_normal;

    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            cnt  <= '0;
            ce   <= 1'b0;
            mode <= 1'b0;
        end else if (align) begin
            cnt <= '0;
            ce  <= 1'b0;
        end else if (pause) begin
            ce <= 1'b0;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            ce  <= 1'b0;
        end else begin
            mode <= turbo;
            if (sel != '0) begin
                ce  <= 1'b1;
                cnt <= sel - CNT_W'(1);
            end else begin
                // Disabled: stay at zero so the divisor is re-read every cycle.
                ce  <= 1'b0;
                cnt <= '0;
            end
        end
    end

endmodule

// File: rtl/ce_gen.sv
// rtl/ce_gen.sv - multi-channel clock-enable generator with normal/turbo divisor sets
//
// Ports:
//   clk_sys, reset_n   clock, asynchronous active-low reset
//   div_normal         packed per-channel divisors, channel i at [i*CNT_W +: CNT_W]
//   div_turbo          packed per-channel turbo divisors, same packing
//   turbo              selects divisor set for the next reload of each channel
//   pause              freezes all counters, suppresses ce
//   align              zeroes all counters so enabled channels fire together next
//   ce                 one registered enable bit per channel
//   mode_ack           registered: all channels reloaded with the current turbo
module ce_gen
    import ce_gen_pkg::*;
#(
    parameter int CHANNELS = 3,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                      clk_sys,
    input  logic                      reset_n,
    input  logic [CHANNELS*CNT_W-1:0] div_normal,
    input  logic [CHANNELS*CNT_W-1:0] div_turbo,
    input  logic                      turbo,
    input  logic                      pause,
    input  logic                      align,
    output logic [CHANNELS-1:0]       ce,
    output logic                      mode_ack
);

    logic [BUS_W-1:0]    normal_bus;
    logic [BUS_W-1:0]    turbo_bus;
    logic [CHANNELS-1:0] mode_bits;

    assign normal_bus = BUS_W'(div_normal);
    assign turbo_bus  = BUS_W'(div_turbo);

    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_chan
        logic [CNT_W-1:0] dn;
        logic [CNT_W-1:0] dt;

        assign dn = CNT_W'(get_div(normal_bus, gi, CNT_W));
        assign dt = CNT_W'(get_div(turbo_bus, gi, CNT_W));

        ce_chan #(
            .CNT_W(CNT_W)
        ) u_chan (
            .clk_sys   (clk_sys),
            .reset_n   (reset_n),
            .div_normal(dn),
            .div_turbo (dt),
            .turbo     (turbo),
            .pause     (pause),
            .align     (align),
            .ce        (ce[gi]),
            .mode      (mode_bits[gi])
        );
    end

    // Compares registered mode bits against the live turbo input, so a turbo
    // toggle drops the acknowledge on the very next edge.
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            mode_ack <= 1'b0;
        end else begin
            mode_ack <= (mode_bits == {CHANNELS{turbo}});
        end
    end

endmodule

// File: doc/ce_gen.md
CE_GEN -- requirements
Module: ce_gen

Interface
REQ-001 Parameter CHANNELS, default 3, number of independent clock-enable outputs (1..8).
REQ-002 Parameter CNT_W, default 4, divisor and counter width per channel (2..8).
REQ-003 clk_sys  input  1  system clock; all logic on rising edge.
REQ-004 reset_n  input  1  reset, asynchronous and active-low.
REQ-005 div_normal  input  CHANNELS*CNT_W  per-channel divisor, normal mode; channel i in bits [i*CNT_W +: CNT_W].
REQ-006 div_turbo  input  CHANNELS*CNT_W  per-channel divisor, turbo mode; same packing.
REQ-007 turbo  input  1  mode select: 0 = normal divisors, 1 = turbo divisors.
REQ-008 pause  input  1  freeze all channels while high.
REQ-009 align  input  1  single-cycle strobe that re-phases all channels.
REQ-010 ce  output  CHANNELS  registered clock-enable pulses, one bit per channel.
REQ-011 mode_ack  output  1  high when every channel runs on the divisor set selected by turbo.

Function
REQ-012 Each channel SHALL hold a down-counter cnt[CNT_W-1:0], a registered ce bit and a registered mode bit (the mode of its last load).
REQ-013 Active cycle = reset_n high, align low, pause low.
REQ-014 Active cycle, cnt != 0: cnt <= cnt-1; ce <= 0.
REQ-015 Active cycle, cnt == 0 (wrap): sel <= turbo ? div_turbo[i] : div_normal[i]; mode bit <= turbo.
REQ-016 Wrap with sel >= 1: ce <= 1; cnt <= sel-1.
REQ-017 Wrap with sel == 0: channel disabled; ce <= 0; cnt <= 0, so the divisor is resampled every cycle.
REQ-018 Resulting duty: divisor D >= 1 gives ce high exactly 1 cycle in every D; D = 1 gives ce constantly high.
REQ-019 Divisor and turbo changes SHALL take effect only at that channel's next wrap; a period in progress is never shortened or stretched (glitch-free switch).
REQ-020 Pause high and align low: cnt and mode bits hold; ce <= 0 for all channels.
REQ-021 After pause falls, counting SHALL resume from the held cnt, so the remaining period length is preserved.
REQ-022 Align high, regardless of pause: all cnt <= 0; all ce <= 0; mode bits hold.
REQ-023 Align followed by an active cycle: all enabled channels SHALL pulse ce together.
REQ-024 Priority SHALL be reset_n, then align, then pause, then count.
REQ-025 mode_ack SHALL be registered: it is high when all channel mode bits equal turbo, and it goes low the cycle after turbo toggles.
REQ-026 Channels SHALL be mutually independent except for the shared turbo, pause and align inputs.

Reset
REQ-027 While reset_n is low: all cnt = 0, ce = 0, mode bits = 0, mode_ack = 0, asynchronously.
REQ-028 First active cycle after release: every enabled channel wraps and pulses ce on the following edge, so all channels start phase-aligned.
REQ-029 Reset asserted mid-period SHALL discard the period with no partial ce pulse.

Structure
REQ-030 Shared package ce_gen_pkg SHALL hold the CNT_W default and the max CHANNELS constant.
REQ-031 Package SHALL hold a divisor typedef of CNT_W bits.
REQ-032 Package SHALL hold a function extracting channel i's divisor from a packed bus.
REQ-033 Sub-module ce_chan SHALL implement one channel (REQ-012..022); ce_gen instantiates CHANNELS copies via generate and owns the mode_ack reduction.
REQ-034 Module SHALL contain no latches, no derived or gated clocks, and no combinational output paths.

Verification
REQ-035 Scenario, basic divide: CHANNELS=3, div_normal={8,4,2}, turbo=0, release reset -> ch0 pulses every 2 cycles, ch1 every 4, ch2 every 8; all three coincide on the first pulse and every 8 cycles after.
REQ-036 Scenario, turbo switch: ch1 div_normal=4, div_turbo=2; raise turbo mid-period -> current 4-cycle period completes; then ce every 2 cycles; mode_ack low 1..4 cycles, then high.
REQ-037 Scenario, pause: ch1 D=4, pause for 10 cycles with cnt=2 -> no ce during pause; first ce exactly 3 cycles after pause falls.
REQ-038 Scenario, align: align pulse with channels at arbitrary phases, including one cycle with pause high -> all ce low that cycle; all fire together on the next active cycle.
REQ-039 Scenario, degenerate divisors: D=0 -> ce never asserted; later change to D=3 -> ce within 1 cycle, then every 3 cycles; D=1 -> ce constantly high.
REQ-040 Scenario, async reset: assert reset_n low asynchronously mid-period -> ce, cnt and mode_ack clear immediately; behaviour after release matches REQ-028.
